// File: rtl/rgb_gray_stage.sv
// rgb_gray_stage: captures LFSR pixels, converts RGB888 to 8-bit luma in a
// 2-stage pipeline and buffers results in a valid/ready FIFO.
module rgb_gray_stage #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          nreset_i,
   input  logic                          en_i,
   input  logic [23:0]                   px_i,
   input  logic                          px_rdy_i,
   input  logic                          px_done_i,
   output logic                          lfsr_en_o,
   output logic [7:0]                    gray_o,
   output logic                          gray_valid_o,
   input  logic                          gray_ready_i,
   output logic                          gray_done_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic            s1_valid_q, s1_valid_d;
   logic [15:0]     r_prod_q, r_prod_d, g_prod_q, g_prod_d, b_prod_q, b_prod_d;
   logic            s2_valid_q, s2_valid_d;
   logic [7:0]      gray2_q, gray2_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d, level_nv;
   logic            overflow_q, overflow_d;
   logic            accept, pop, push, drop, full, drained, abort, start;
   logic [15:0]     sum;

   assign lfsr_en_o    = state_q == RUN;
   assign gray_done_o  = state_q == DONE;
   assign gray_valid_o = level_q != '0;
   assign gray_o       = mem_q[rd_ptr_q];
   assign overflow_o   = overflow_q;
   assign fifo_level_o = level_q;

   always_comb begin
      accept   = state_q == RUN && px_rdy_i && !px_done_i;
      pop      = gray_valid_o && gray_ready_i;
      full     = level_q == LW'(FIFO_DEPTH);
      push     = s2_valid_q && (!full || pop);
      drop     = s2_valid_q && !push;
      level_nv = level_q + LW'(push) - LW'(pop);
      drained  = !accept && !s1_valid_q && level_nv == '0;
      sum      = r_prod_q + g_prod_q + b_prod_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = en_i ? RUN : IDLE;
         RUN:     state_d = !en_i ? IDLE : px_done_i ? DRAIN : RUN;
         DRAIN:   state_d = !en_i ? IDLE : drained ? DONE : DRAIN;
         default: state_d = !en_i ? IDLE : DONE;
      endcase
      abort = state_q != IDLE && state_d == IDLE;
      start = state_q == IDLE && state_d == RUN;
   end

   // Coefficients sum to 256, so the top byte of the product sum is the luma.
   always_comb begin
      s1_valid_d = !abort && accept;
      r_prod_d   = accept ? 16'(px_i[23:16]) * 16'd77  : r_prod_q;
      g_prod_d   = accept ? 16'(px_i[15:8])  * 16'd150 : g_prod_q;
      b_prod_d   = accept ? 16'(px_i[7:0])   * 16'd29  : b_prod_q;
      s2_valid_d = !abort && s1_valid_q;
      gray2_d    = s1_valid_q ? sum[15:8] : gray2_q;
      mem_d      = mem_q;
      if (push && !abort) mem_d[wr_ptr_q] = gray2_q;
      wr_ptr_d   = abort ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d   = abort ? '0 : rd_ptr_q + AW'(pop);
      level_d    = abort ? '0 : level_nv;
      overflow_d = start ? 1'b0 : overflow_q | drop;
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q    <= IDLE;
         s1_valid_q <= 1'b0;
         r_prod_q   <= '0;
         g_prod_q   <= '0;
         b_prod_q   <= '0;
         s2_valid_q <= 1'b0;
         gray2_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         r_prod_q   <= r_prod_d;
         g_prod_q   <= g_prod_d;
         b_prod_q   <= b_prod_d;
         s2_valid_q <= s2_valid_d;
         gray2_q    <= gray2_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_rgb_gray_stage.sv
// tb_rgb_gray_stage: directed table-driven bench for rgb_gray_stage.
module tb_rgb_gray_stage;
   logic        clk_i = 1'b0, nreset_i = 1'b0, en_i = 1'b0;
   logic        px_rdy_i = 1'b0, px_done_i = 1'b0, gray_ready_i = 1'b0;
   logic [23:0] px_i = '0;
   logic        lfsr_en_o, gray_valid_o, gray_done_o, overflow_o;
   logic [7:0]  gray_o;
   logic [2:0]  fifo_level_o;

   rgb_gray_stage #(.FIFO_DEPTH(4)) dut (
      .clk_i(clk_i), .nreset_i(nreset_i), .en_i(en_i), .px_i(px_i),
      .px_rdy_i(px_rdy_i), .px_done_i(px_done_i), .lfsr_en_o(lfsr_en_o),
      .gray_o(gray_o), .gray_valid_o(gray_valid_o), .gray_ready_i(gray_ready_i),
      .gray_done_o(gray_done_o), .overflow_o(overflow_o), .fifo_level_o(fifo_level_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [23:0] px;
      logic [7:0]  g;
   } vec_t;

   vec_t       tbl [7];
   int         checks = 0, failures = 0, cyc = 0, last_pop = -1, first_done, maxl;
   logic [7:0] popq [$];
   logic       done_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Record a pop just before the edge that performs it, then advance one cycle.
   task automatic step();
      if (gray_valid_o && gray_ready_i) begin
         popq.push_back(gray_o);
         last_pop = cyc;
      end
      @(posedge clk_i);
      #1;
      cyc++;
      done_seen = done_seen | gray_done_o;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " lfsr_en"}, 32'(lfsr_en_o), 0);
      check({tag, " gray"}, 32'(gray_o), 0);
      check({tag, " valid"}, 32'(gray_valid_o), 0);
      check({tag, " done"}, 32'(gray_done_o), 0);
      check({tag, " overflow"}, 32'(overflow_o), 0);
      check({tag, " level"}, 32'(fifo_level_o), 0);
   endtask

   initial begin
      tbl[0] = '{24'hFF0000, 8'h4C};
      tbl[1] = '{24'h00FF00, 8'h95};
      tbl[2] = '{24'h0000FF, 8'h1C};
      tbl[3] = '{24'hFFFFFF, 8'hFF};
      tbl[4] = '{24'h000000, 8'h00};
      tbl[5] = '{24'h808080, 8'h80};
      tbl[6] = '{24'h102030, 8'h1D};
      done_seen = 1'b0;

      repeat (2) @(posedge clk_i);
      #1;
      check_zero("reset");
      #2 nreset_i = 1'b1;

      // conversion and latency, one pixel per run
      gray_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         en_i = 1'b1;
         step();
         check($sformatf("conv%0d lfsr_en", i), 32'(lfsr_en_o), 1);
         px_i = tbl[i].px;
         px_rdy_i = 1'b1;
         step();
         px_rdy_i = 1'b0;
         step();
         check($sformatf("conv%0d early_valid", i), 32'(gray_valid_o), 0);
         step();
         check($sformatf("conv%0d valid", i), 32'(gray_valid_o), 1);
         check($sformatf("conv%0d gray", i), 32'(gray_o), 32'(tbl[i].g));
         en_i = 1'b0;
         step();
         check($sformatf("conv%0d level_after", i), 32'(fifo_level_o), 0);
      end

      // streaming 8 pixels with ready high
      popq.delete();
      en_i = 1'b1;
      step();
      maxl = 0;
      for (int c = 0; c < 16; c++) begin
         px_rdy_i = c < 8;
         px_i = tbl[c % 7].px;
         step();
         if (int'(fifo_level_o) > maxl) maxl = int'(fifo_level_o);
      end
      check("stream count", popq.size(), 8);
      for (int k = 0; k < popq.size() && k < 8; k++)
         check($sformatf("stream out%0d", k), 32'(popq[k]), 32'(tbl[k % 7].g));
      check("stream level_le1", 32'(maxl <= 1), 1);
      check("stream overflow", 32'(overflow_o), 0);
      en_i = 1'b0;
      step();

      // overflow with ready low
      popq.delete();
      gray_ready_i = 1'b0;
      en_i = 1'b1;
      step();
      for (int c = 0; c < 6; c++) begin
         px_i = tbl[c].px;
         px_rdy_i = 1'b1;
         step();
      end
      px_rdy_i = 1'b0;
      repeat (3) step();
      check("ovf level", 32'(fifo_level_o), 4);
      check("ovf flag", 32'(overflow_o), 1);
      check("ovf head", 32'(gray_o), 32'(tbl[0].g));
      gray_ready_i = 1'b1;
      repeat (8) step();
      check("ovf pops", popq.size(), 4);
      for (int k = 0; k < popq.size() && k < 4; k++)
         check($sformatf("ovf out%0d", k), 32'(popq[k]), 32'(tbl[k].g));
      check("ovf level_end", 32'(fifo_level_o), 0);
      en_i = 1'b0;
      step();
      check("ovf sticky_idle", 32'(overflow_o), 1);
      en_i = 1'b1;
      step();
      check("ovf cleared_rerun", 32'(overflow_o), 0);
      en_i = 1'b0;
      step();

      // drain and done: four pixels then the stop value
      popq.delete();
      en_i = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         px_i = (i == 4) ? tbl[3].px : tbl[(i == 3) ? 5 : i].px;
         px_rdy_i = 1'b1;
         px_done_i = i == 4;
         step();
         if (i == 3) check("drain lfsr_en_before", 32'(lfsr_en_o), 1);
      end
      check("drain lfsr_en_fall", 32'(lfsr_en_o), 0);
      px_rdy_i = 1'b0;
      first_done = -1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (gray_done_o && first_done < 0) first_done = cyc;
      end
      check("drain count", popq.size(), 4);
      for (int k = 0; k < popq.size() && k < 4; k++)
         check($sformatf("drain out%0d", k), 32'(popq[k]), 32'(tbl[(k == 3) ? 5 : k].g));
      check("drain done_timing", 32'(first_done), 32'(last_pop + 1));
      check("drain done_held", 32'(gray_done_o), 1);
      en_i = 1'b0;
      px_done_i = 1'b0;
      step();
      check("drain done_clear", 32'(gray_done_o), 0);

      // abort with three entries buffered
      gray_ready_i = 1'b0;
      en_i = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         px_i = tbl[i].px;
         px_rdy_i = 1'b1;
         step();
      end
      px_rdy_i = 1'b0;
      repeat (3) step();
      check("abort level_before", 32'(fifo_level_o), 3);
      done_seen = 1'b0;
      en_i = 1'b0;
      step();
      check("abort level", 32'(fifo_level_o), 0);
      check("abort valid", 32'(gray_valid_o), 0);
      check("abort lfsr_en", 32'(lfsr_en_o), 0);
      repeat (3) step();
      check("abort no_done", 32'(done_seen), 0);

      // async reset mid-DRAIN with a full FIFO
      en_i = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         px_i = tbl[i].px;
         px_rdy_i = 1'b1;
         px_done_i = i == 4;
         step();
      end
      px_rdy_i = 1'b0;
      repeat (2) step();
      check("rst level_full", 32'(fifo_level_o), 4);
      check("rst in_drain", 32'(lfsr_en_o), 0);
      #2 nreset_i = 1'b0;
      #1 check_zero("async_rst");
      px_done_i = 1'b0;
      #1 nreset_i = 1'b1;
      gray_ready_i = 1'b1;
      step();
      check("resume lfsr_en", 32'(lfsr_en_o), 1);
      px_i = tbl[0].px;
      px_rdy_i = 1'b1;
      step();
      px_rdy_i = 1'b0;
      repeat (2) step();
      check("resume valid", 32'(gray_valid_o), 1);
      check("resume gray", 32'(gray_o), 32'(tbl[0].g));
      en_i = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
